// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bundle for the sequential ALU.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_MUL  = 4'b0010;
    localparam logic [OP_W-1:0] OP_DIV  = 4'b0011;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0100;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0101;
    localparam logic [OP_W-1:0] OP_NAND = 4'b0110;
    localparam logic [OP_W-1:0] OP_NOR  = 4'b0111;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b1000;
    localparam logic [OP_W-1:0] OP_XNOR = 4'b1001;
    localparam logic [OP_W-1:0] OP_NOTA = 4'b1010;
    localparam logic [OP_W-1:0] OP_REM  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
        logic div_zero;
    } alu_flags_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one shift register.
// The first iteration is folded into the start cycle so done rises after WIDTH-1 more edges.
module alu_iter_muldiv #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic [WIDTH-1:0] lo_q, hi_q, b_q;
    logic             mode_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] lo_src, hi_src, b_src;
    logic             mode_src;
    logic [WIDTH:0]   add_v;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] lo_nxt, hi_nxt;

    // One multiply or divide step, taken from fresh operands on start
    always_comb begin
        hi_src   = start ? '0   : hi_q;
        lo_src   = start ? a    : lo_q;
        b_src    = start ? b    : b_q;
        mode_src = start ? mode : mode_q;
        add_v    = lo_src[0] ? ({1'b0, hi_src} + {1'b0, b_src}) : {1'b0, hi_src};
        shifted  = {hi_src, lo_src[WIDTH-1]};
        diff     = shifted[WIDTH-1:0] - b_src;
        hi_nxt   = hi_src;
        lo_nxt   = lo_src;
        if (mode_src) begin
            hi_nxt = add_v[WIDTH:1];
            lo_nxt = {add_v[0], lo_src[WIDTH-1:1]};
        end else if (shifted >= {1'b0, b_src}) begin
            hi_nxt = diff;
            lo_nxt = {lo_src[WIDTH-2:0], 1'b1};
        end else begin
            hi_nxt = shifted[WIDTH-1:0];
            lo_nxt = {lo_src[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lo_q   <= '0;
            hi_q   <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            done   <= 1'b0;
        end else if (start) begin
            lo_q   <= lo_nxt;
            hi_q   <= hi_nxt;
            b_q    <= b;
            mode_q <= mode;
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(1);
            done   <= 1'b0;
        end else if (busy_q) begin
            if (done) begin
                busy_q <= 1'b0;
                done   <= 1'b0;
            end else begin
                lo_q  <= lo_nxt;
                hi_q  <= hi_nxt;
                cnt_q <= cnt_q + CNT_W'(1);
                done  <= (cnt_q == CNT_W'(WIDTH - 1));
            end
        end
    end

    assign lo = lo_q;
    assign hi = hi_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake; single-cycle ops computed here,
// MUL/DIV/REM delegated to the iterative unit.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             zero_flag,
    output logic             negative_flag,
    output logic             div_zero_flag
);

    localparam int unsigned MSB = WIDTH - 1;

    state_t           state;
    logic [OP_W-1:0]  op_q;
    alu_flags_t       flags_q;

    logic             is_mul, is_divrem, b_zero;
    logic             md_start, md_done;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic [WIDTH:0]   sum_c, dif_c;
    logic [WIDTH-1:0] res_c, fin_res_c;
    alu_flags_t       flags_c, fin_flags_c;

    assign is_mul    = (select == OP_MUL);
    assign is_divrem = (select == OP_DIV) || (select == OP_REM);
    assign b_zero    = (b == '0);
    assign md_start  = (state == IDLE) && in_valid && (is_mul || (is_divrem && !b_zero));

    alu_iter_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .mode  (is_mul),
        .a     (a),
        .b     (b),
        .done  (md_done),
        .lo    (md_lo),
        .hi    (md_hi)
    );

    // Single-cycle result; DIV/REM here only matter for the b == 0 case
    always_comb begin
        sum_c   = {1'b0, a} + {1'b0, b};
        dif_c   = {1'b0, a} - {1'b0, b};
        res_c   = '0;
        flags_c = '0;
        case (select)
            OP_ADD: begin
                res_c            = sum_c[WIDTH-1:0];
                flags_c.carry    = sum_c[WIDTH];
                flags_c.overflow = (a[MSB] == b[MSB]) && (sum_c[MSB] != a[MSB]);
            end
            OP_SUB: begin
                res_c            = dif_c[WIDTH-1:0];
                flags_c.carry    = dif_c[WIDTH];
                flags_c.overflow = (a[MSB] != b[MSB]) && (dif_c[MSB] != a[MSB]);
            end
            OP_DIV, OP_REM: flags_c.div_zero = b_zero;
            OP_AND:  res_c = a & b;
            OP_OR:   res_c = a | b;
            OP_NAND: res_c = ~(a & b);
            OP_NOR:  res_c = ~(a | b);
            OP_XOR:  res_c = a ^ b;
            OP_XNOR: res_c = ~(a ^ b);
            OP_NOTA: res_c = ~a;
            default: res_c = '0;
        endcase
        flags_c.zero     = (res_c == '0);
        flags_c.negative = res_c[MSB];
    end

    // Final MUL/DIV/REM result once the iterative unit finishes
    always_comb begin
        fin_res_c         = (op_q == OP_REM) ? md_hi : md_lo;
        fin_flags_c       = '0;
        fin_flags_c.carry = (op_q == OP_MUL) && (md_hi != '0);
        fin_flags_c.zero     = (fin_res_c == '0);
        fin_flags_c.negative = fin_res_c[MSB];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flags_q   <= '0;
            op_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= select;
                        in_ready <= 1'b0;
                        if (is_mul) begin
                            state <= MUL;
                        end else if (is_divrem && !b_zero) begin
                            state <= DIV;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= res_c;
                            flags_q   <= flags_c;
                        end
                    end
                end
                MUL, DIV: begin
                    if (md_done) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= fin_res_c;
                        flags_q   <= fin_flags_c;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign carry_flag    = flags_q.carry;
    assign overflow_flag = flags_q.overflow;
    assign zero_flag     = flags_q.zero;
    assign negative_flag = flags_q.negative;
    assign div_zero_flag = flags_q.div_zero;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] select;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry_flag;
    logic       overflow_flag;
    logic       zero_flag;
    logic       negative_flag;
    logic       div_zero_flag;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a             (a),
        .b             (b),
        .select        (select),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .zero_flag     (zero_flag),
        .negative_flag (negative_flag),
        .div_zero_flag (div_zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] flags_now();
        return {carry_flag, overflow_flag, zero_flag, negative_flag, div_zero_flag};
    endfunction

    // Waits for in_ready, issues one request, returns cycles from accept edge to out_valid
    task automatic issue(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb,
                         output int lat);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        select   = op;
        a        = va;
        b        = vb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] res;
        logic [4:0] flg;  // {carry, overflow, zero, negative, div_zero}
        int         lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat;
        int seen;
        string tag;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        select    = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'(flags_now()), 32'd0);
        rst_n = 1'b1;

        vecs.push_back('{4'b0000, 8'h7F, 8'h01, 8'h80, 5'b01010, 1});
        vecs.push_back('{4'b0001, 8'h00, 8'h01, 8'hFF, 5'b10010, 1});
        vecs.push_back('{4'b0000, 8'hFF, 8'h01, 8'h00, 5'b10100, 1});
        vecs.push_back('{4'b0000, 8'h80, 8'h80, 8'h00, 5'b11100, 1});
        vecs.push_back('{4'b0001, 8'h80, 8'h01, 8'h7F, 5'b01000, 1});
        vecs.push_back('{4'b0010, 8'h10, 8'h10, 8'h00, 5'b10100, 9});
        vecs.push_back('{4'b0010, 8'h0C, 8'h0B, 8'h84, 5'b00010, 9});
        vecs.push_back('{4'b0010, 8'hFF, 8'hFF, 8'h01, 5'b10000, 9});
        vecs.push_back('{4'b0010, 8'h05, 8'h00, 8'h00, 5'b00100, 9});
        vecs.push_back('{4'b0011, 8'hC8, 8'h07, 8'h1C, 5'b00000, 9});
        vecs.push_back('{4'b1011, 8'hC8, 8'h07, 8'h04, 5'b00000, 9});
        vecs.push_back('{4'b0011, 8'h05, 8'h00, 8'h00, 5'b00101, 1});
        vecs.push_back('{4'b1011, 8'h05, 8'h00, 8'h00, 5'b00101, 1});
        vecs.push_back('{4'b1011, 8'h07, 8'hC8, 8'h07, 5'b00000, 9});
        vecs.push_back('{4'b0011, 8'hFF, 8'h01, 8'hFF, 5'b00010, 9});
        vecs.push_back('{4'b0100, 8'hF0, 8'h3C, 8'h30, 5'b00000, 1});
        vecs.push_back('{4'b0101, 8'hF0, 8'h3C, 8'hFC, 5'b00010, 1});
        vecs.push_back('{4'b0110, 8'hF0, 8'h3C, 8'hCF, 5'b00010, 1});
        vecs.push_back('{4'b0111, 8'hF0, 8'h3C, 8'h03, 5'b00000, 1});
        vecs.push_back('{4'b1001, 8'hAA, 8'h0F, 8'h5A, 5'b00000, 1});
        vecs.push_back('{4'b1010, 8'h55, 8'h00, 8'hAA, 5'b00010, 1});
        vecs.push_back('{4'b1110, 8'h12, 8'h34, 8'h00, 5'b00100, 1});

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].va, vecs[i].vb, lat);
            tag = $sformatf("v%0d_op%0h", i, vecs[i].op);
            check({tag, "_lat"}, 32'(lat), 32'(vecs[i].lat));
            check({tag, "_res"}, 32'(result), 32'(vecs[i].res));
            check({tag, "_flags"}, 32'(flags_now()), 32'(vecs[i].flg));
            check({tag, "_busy"}, 32'(in_ready), 32'd0);
        end

        // Backpressure: result and flags must hold while the consumer stalls
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(4'b1000, 8'hAA, 8'h0F, lat);
        check("xor_lat", 32'(lat), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_res", 32'(result), 32'hA5);
            check("bp_flags", 32'(flags_now()), 32'b00010);
            check("bp_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        select   = 4'b0000;
        a        = 8'h01;
        b        = 8'h02;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("post_bp_valid", 32'(out_valid), 32'd1);
        check("post_bp_res", 32'(result), 32'h03);

        // Reset in the middle of a multiply aborts it without any output
        @(posedge clk); #1;
        in_valid = 1'b1;
        select   = 4'b0010;
        a        = 8'h0C;
        b        = 8'h0B;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid_mul_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_res", 32'(result), 32'd0);
        check("abort_flags", 32'(flags_now()), 32'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_stale", 32'(seen), 32'd0);

        issue(4'b1110, 8'hFF, 8'hFF, lat);
        check("rsvd_lat", 32'(lat), 32'd1);
        check("rsvd_res", 32'(result), 32'd0);
        check("rsvd_flags", 32'(flags_now()), 32'b00100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
